// File: rtl/mem_pkg.sv
// Shared encodings for the load/store unit: access sizes, FSM states and
// the lane-offset width derived from the SRAM word width.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WRITE,
    ST_RESP
  } state_e;

  function automatic int lane_off_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus SRAM pins of the load/store unit.
// The unit takes the slave view; the execute stage / SRAM side takes master.
interface mem_access_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
);
  import mem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;
  logic              mem_cen_n;
  logic              mem_wen_n;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_d;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  resp_ready, mem_q,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_cen_n, mem_wen_n, mem_addr, mem_d
  );

  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output resp_ready, mem_q,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_cen_n, mem_wen_n, mem_addr, mem_d
  );

endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane handling: load extract/extend, sub-word store merge,
// and the alignment / range / size error check.
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input  logic [31:0]       addr_i,
  input  logic [1:0]        size_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] load_o,
  output logic [DATA_W-1:0] merge_o,
  output logic              full_o,
  output logic              err_o
);
  localparam int OFF_W = lane_off_w(DATA_W);

  logic [OFF_W-1:0]  off;
  logic [OFF_W+2:0]  sh;
  logic [6:0]        nbits;
  logic [DATA_W-1:0] mask;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] lane_mask;
  logic              sbit;
  logic              misal;
  logic              range_err;
  logic              size_err;

  always_comb begin
    off     = addr_i[OFF_W-1:0];
    sh      = {off, 3'b000};
    nbits   = 7'd8 << size_i;
    // a shift by >= DATA_W yields zero, so full-width sizes get an all-ones mask
    mask    = ~({DATA_W{1'b1}} << nbits);
    shifted = word_i >> sh;
    sbit    = |(shifted & (mask ^ (mask >> 1)));
    load_o  = (signed_i && sbit) ? (shifted | ~mask) : (shifted & mask);

    lane_mask = mask << sh;
    merge_o   = (word_i & ~lane_mask) | ((wdata_i << sh) & lane_mask);
    full_o    = (nbits == 7'(DATA_W));

    case (size_i)
      SZ_B:    misal = 1'b0;
      SZ_H:    misal = off[0];
      SZ_W:    misal = |off[1:0];
      default: misal = |off;
    endcase
    range_err = (addr_i >> (ADDR_W + OFF_W)) != 32'd0;
    size_err  = (size_i == SZ_D) && (DATA_W == 32);
    err_o     = misal | range_err | size_err;
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit in front of a single-port SRAM with active-low enables and
// no byte mask; sub-word stores are done as read-modify-write.
//   state    | meaning
//   IDLE     | ready for a request
//   RD_WAIT  | SRAM read issued, counting down read latency
//   WRITE    | SRAM write issued (full-width or merged RMW word)
//   RESP     | response held until consumer accepts
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 11,
  parameter int WAIT_CYCLES = 1
) (
  input logic            clk,
  input logic            rst,
  mem_access_unit_if.slave bus
);
  localparam int OFF_W = lane_off_w(DATA_W);
  localparam int CNT_W = $clog2(WAIT_CYCLES + 2);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic              signed_q, signed_d;
  logic [31:0]       addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              cen_n_q, cen_n_d;
  logic              wen_n_q, wen_n_d;
  logic [ADDR_W-1:0] maddr_q, maddr_d;
  logic [DATA_W-1:0] md_q, md_d;

  logic              idle;
  logic [31:0]       al_addr;
  logic [1:0]        al_size;
  logic              al_signed;
  logic [DATA_W-1:0] al_wdata;
  logic [DATA_W-1:0] al_load;
  logic [DATA_W-1:0] al_merge;
  logic              al_full;
  logic              al_err;

  // in IDLE the checker looks at the live request, afterwards at the registered one
  assign idle      = (state_q == ST_IDLE);
  assign al_addr   = idle ? bus.req_addr   : addr_q;
  assign al_size   = idle ? bus.req_size   : size_q;
  assign al_signed = idle ? bus.req_signed : signed_q;
  assign al_wdata  = idle ? bus.req_wdata  : wdata_q;

  mem_lane_align #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_align (
    .addr_i   (al_addr),
    .size_i   (al_size),
    .signed_i (al_signed),
    .word_i   (bus.mem_q),
    .wdata_i  (al_wdata),
    .load_o   (al_load),
    .merge_o  (al_merge),
    .full_o   (al_full),
    .err_o    (al_err)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    size_d       = size_q;
    signed_d     = signed_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    cen_n_d      = cen_n_q;
    wen_n_d      = wen_n_q;
    maddr_d      = maddr_q;
    md_d         = md_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          we_d        = bus.req_we;
          size_d      = bus.req_size;
          signed_d    = bus.req_signed;
          addr_d      = bus.req_addr;
          wdata_d     = bus.req_wdata;
          maddr_d     = bus.req_addr[ADDR_W+OFF_W-1:OFF_W];
          req_ready_d = 1'b0;
          if (al_err) begin
            state_d      = ST_RESP;
            resp_valid_d = 1'b1;
            err_d        = 1'b1;
            rdata_d      = '0;
          end else if (bus.req_we && al_full) begin
            // one pad cycle in WRITE keeps full-width store latency at two edges
            state_d = ST_WRITE;
            cen_n_d = 1'b0;
            wen_n_d = 1'b0;
            md_d    = bus.req_wdata;
            cnt_d   = CNT_W'(1);
          end else begin
            state_d = ST_RD_WAIT;
            cen_n_d = 1'b0;
            wen_n_d = 1'b1;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      ST_RD_WAIT: begin
        cen_n_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (we_q) begin
          state_d = ST_WRITE;
          cen_n_d = 1'b0;
          wen_n_d = 1'b0;
          md_d    = al_merge;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          rdata_d      = al_load;
          err_d        = 1'b0;
        end
      end
      ST_WRITE: begin
        cen_n_d = 1'b1;
        wen_n_d = 1'b1;
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d      = ST_RESP;
          resp_valid_d = 1'b1;
          rdata_d      = '0;
          err_d        = 1'b0;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready) begin
          state_d      = ST_IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
          rdata_d      = '0;
          err_d        = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
      cen_n_q      <= 1'b1;
      wen_n_q      <= 1'b1;
      maddr_q      <= '0;
      md_q         <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      size_q       <= size_d;
      signed_q     <= signed_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
      cen_n_q      <= cen_n_d;
      wen_n_q      <= wen_n_d;
      maddr_q      <= maddr_d;
      md_q         <= md_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_cen_n  = cen_n_q;
  assign bus.mem_wen_n  = wen_n_q;
  assign bus.mem_addr   = maddr_q;
  assign bus.mem_d      = md_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Parametrised load/store unit between the execute stage and a single-port synchronous SRAM. The SRAM has active-low chip and write enables and no byte mask.
- Accepts one byte/half/word(/dword) request per valid/ready handshake.
- Checks alignment and range.
- Performs sign/zero extension on loads.
- Implements sub-word stores as read-modify-write.
- Supports configurable SRAM read latency and memory depth.

Parameters:
DATA_W, 32, SRAM word width; legal values 32 or 64.
ADDR_W, 11, SRAM word-address width; depth = 2**ADDR_W words.
WAIT_CYCLES, 1, SRAM read latency in cycles (>=1).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  reset, asynchronous, active-high.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request (IDLE only).
req_we  in  1  1=store, 0=load.
req_size  in  2  0=byte, 1=half, 2=word, 3=dword (DATA_W=64 only).
req_signed  in  1  sign-extend load result.
req_addr  in  32  byte address.
req_wdata  in  DATA_W  store data, right-aligned.
resp_valid  out  1  response present.
resp_ready  in  1  consumer accepts response.
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
resp_err  out  1  misaligned, out-of-range or illegal size.
mem_cen_n  out  1  SRAM chip enable, active low.
mem_wen_n  out  1  SRAM write enable, active low.
mem_addr  out  ADDR_W  SRAM word address.
mem_d  out  DATA_W  SRAM write data.
mem_q  in  DATA_W  SRAM read data.

Behaviour:
- Reset (async): state IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_cen_n=1; mem_wen_n=1; mem_addr=0; mem_d=0; wait counter=0.
- All outputs are registered. The SRAM samples on the rising edge at which mem_cen_n=0. mem_q is captured WAIT_CYCLES edges after that sampling edge.
- Lanes are little-endian. Lane offset = req_addr[log2(DATA_W/8)-1:0]. Word index = req_addr[ADDR_W+log2(DATA_W/8)-1 : log2(DATA_W/8)].
- Error if any of the following holds: offset not a multiple of the access size; any req_addr bit above the word index is nonzero; size 3 with DATA_W=32.
- Error path: no SRAM access. resp_valid=1, resp_err=1, resp_rdata=0 one edge after accept.
- States: IDLE, RD_WAIT, WRITE, RESP.
- IDLE: on req_valid&&req_ready (edge E0), register the request.
  - Error -> RESP.
  - Full-width store -> WRITE (mem_cen_n=0, mem_wen_n=0, mem_d=wdata).
  - Otherwise -> RD_WAIT (mem_cen_n=0, mem_wen_n=1). Counter loaded with WAIT_CYCLES.
- RD_WAIT:
  - mem_cen_n returns to 1 after one cycle.
  - Counter decrements each edge.
  - At edge E0+1+WAIT_CYCLES, capture mem_q.
  - Load -> RESP, with extracted lane extended per req_signed.
  - Sub-word store -> WRITE, with mem_d = captured word with the lane replaced by low bits of wdata; mem_cen_n=0, mem_wen_n=0.
- WRITE: one cycle; then mem_cen_n=mem_wen_n=1 -> RESP with rdata=0, err=0.
- RESP: resp_valid held with stable data until resp_valid&&resp_ready, then -> IDLE. req_ready=0 outside IDLE, so there is no overlap of requests.
- Latency to resp_valid (edges after E0):
  - error: 1.
  - full-width store: 2.
  - load: 1+WAIT_CYCLES.
  - sub-word store: 2+WAIT_CYCLES.
- Exactly one SRAM write per store; never a write for a load or an error.
- Reset mid-operation: aborts immediately. mem_cen_n/mem_wen_n go to 1 asynchronously, so an RMW cut before its WRITE edge leaves memory unchanged. No response is produced.
- req_* inputs are ignored outside IDLE; register values, not live inputs, drive all later cycles.

Decomposition:
- Package mem_pkg:
  - size encodings (SZ_B/SZ_H/SZ_W/SZ_D)
  - state enum
  - helper constant for lane-offset width as a function of DATA_W.
- Sub-module mem_lane_align (combinational), which provides:
  - extract+extend from a word given offset/size/signed
  - merge of store data into a word
  - alignment/range error flag.
- The FSM, counter and registers stay in mem_access_unit.

Test Plan:
1. DATA_W=32, ADDR_W=11, WAIT_CYCLES=1, word 0x8070F0A1 preloaded at byte 0x10:
   - signed byte load 0x10 -> resp_rdata=0xFFFFFFA1, resp_valid at E0+2.
   - unsigned byte load 0x13 -> 0x00000080.
   - signed half load 0x12 -> 0xFFFF8070.
2. Half store 0xBEEF to 0x12 over 0x8070F0A1 -> one read then one write, SRAM word 0xBEEFF0A1, resp_valid at E0+3, rdata=0, err=0.
3. Word load 0x06 (misaligned) and word load 0x2000 (out of range) -> resp_err=1, rdata=0 at E0+1; mem_cen_n never 0.
4. WAIT_CYCLES=3, word load 0x10 -> resp_valid at E0+4 with 0x8070F0A1; req_ready=0 throughout; captured value unaffected by mem_q changes after the capture edge.
5. resp_ready held 0 for 5 cycles after resp_valid -> rdata/err stable, req_ready=0, a second req_valid is not accepted until the cycle after the handshake.
6. rst pulsed during RD_WAIT of a byte store to 0x10 -> mem_wen_n never 0, word stays 0x8070F0A1, resp_valid=0, req_ready=1 after rst drops.
